// File: rtl/cont_pkg.sv
// Shared encodings and default timing constants for the run/pause/direction counter controller.
package cont_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Board build: 50 MHz clock, 1 s count period, 20 ms debounce.
    localparam int unsigned BOARD_PRESCALE   = 50000000;
    localparam int unsigned BOARD_DEB_CYCLES = 1000000;
    localparam int unsigned BOARD_PS_W       = 26;

    // Short values that keep simulation runs small.
    localparam int unsigned SIM_PRESCALE   = 4;
    localparam int unsigned SIM_DEB_CYCLES = 3;
    localparam int unsigned SIM_PS_W       = 3;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw push-button, debounces its level and emits one pulse per accepted press.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample that agrees with the current level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            cnt_q       <= '0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/cont_ctrl.sv
// Start/stop/direction controller: debounced keys drive a run FSM that issues prescaled,
// single-cycle count enables and stops the counter at its terminal value.
module cont_ctrl import cont_pkg::*; #(
    parameter int unsigned PRESCALE   = BOARD_PRESCALE,
    parameter int unsigned DEB_CYCLES = BOARD_DEB_CYCLES,
    parameter int unsigned PS_W       = BOARD_PS_W
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_dir,
    input  logic       tc_in,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic       done
);

    logic start_p, dir_p;
    logic start_lvl, dir_lvl;
    logic unused_levels;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk       (clk),
        .clr       (clr),
        .btn_raw   (btn_start),
        .btn_level (start_lvl),
        .btn_pulse (start_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk       (clk),
        .clr       (clr),
        .btn_raw   (btn_dir),
        .btn_level (dir_lvl),
        .btn_pulse (dir_p)
    );

    assign unused_levels = start_lvl ^ dir_lvl;

    state_e          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            cnt_en_q, cnt_en_d;
    logic            cnt_up_q, cnt_up_d;
    logic            cnt_clr_q, cnt_clr_d;
    logic            done_q, done_d;
    logic            tick;

    assign tick = (state_q == ST_RUN) && (ps_q == PS_W'(PRESCALE - 1));

    always_comb begin
        state_d   = state_q;
        ps_d      = ps_q;
        cnt_en_d  = 1'b0;
        cnt_up_d  = cnt_up_q;
        cnt_clr_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ps_d = '0;
                if (dir_p) cnt_up_d = ~cnt_up_q;
                if (start_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                ps_d = tick ? '0 : ps_q + PS_W'(1);
                // A stop request wins over a coincident tick, so no enable slips out.
                if (start_p) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (tc_in) state_d  = ST_DONE;
                    else       cnt_en_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (dir_p) cnt_up_d = ~cnt_up_q;
                if (start_p) state_d = ST_RUN;
            end
            ST_DONE: begin
                ps_d = '0;
                if (start_p) begin
                    state_d   = ST_IDLE;
                    cnt_clr_d = 1'b1;
                    cnt_up_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            ps_q      <= '0;
            cnt_en_q  <= 1'b0;
            cnt_up_q  <= 1'b1;
            cnt_clr_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            cnt_en_q  <= cnt_en_d;
            cnt_up_q  <= cnt_up_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign cnt_up  = cnt_up_q;
    assign cnt_clr = cnt_clr_q;
    assign state   = state_q;
    assign done    = done_q;

endmodule
